// File: rtl/fb_pkg.sv
// Shared constants, register map, FSM state type and write-queue entry type
// for the frame-buffer access controller.
package fb_pkg;

   localparam int FB_H_RES  = 640;
   localparam int FB_V_RES  = 480;
   localparam int FB_SIZE   = FB_H_RES * FB_V_RES;
   localparam int FB_ADDR_W = 19;
   localparam int FB_DATA_W = 8;

   // Avalon register indices
   localparam logic [2:0] REG_X_LO   = 3'd0;
   localparam logic [2:0] REG_X_HI   = 3'd1;
   localparam logic [2:0] REG_Y_LO   = 3'd2;
   localparam logic [2:0] REG_Y_HI   = 3'd3;
   localparam logic [2:0] REG_COLOR  = 3'd4;
   localparam logic [2:0] REG_COMMIT = 3'd5;
   localparam logic [2:0] REG_FILL   = 3'd6;
   localparam logic [2:0] REG_STATUS = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_FILL  = 2'd2
   } fb_state_e;

   typedef struct packed {
      logic [FB_ADDR_W-1:0] addr;
      logic [FB_DATA_W-1:0] data;
   } fb_wr_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO of pending host pixel writes. A push is accepted
// while full as long as a pop happens in the same cycle.
module fb_wr_fifo
   import fb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  fb_wr_t                   i_data,
   input  logic                     i_pop,
   output fb_wr_t                   o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PW = $clog2(DEPTH);

   fb_wr_t           r_mem [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [PW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == (PW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Entry storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wptr] <= i_data;
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/fb_access_ctrl.sv
// Frame-buffer access controller: arbitrates the single-port RAM between VGA
// scanout reads (strict priority), queued host pixel writes and a hardware
// fill-screen engine.
//
// Handshake: scan_req is a request with no back-pressure; the RAM is granted
// to scanout in that same cycle and scan_valid/scan_data follow exactly one
// cycle later. Host writes are fire-and-forget via COMMIT; drops are reported
// through the sticky error bits.
module fb_access_ctrl
   import fb_pkg::*;
#(
   parameter int H_RES      = FB_H_RES,
   parameter int V_RES      = FB_V_RES,
   parameter int ADDR_W     = FB_ADDR_W,
   parameter int DATA_W     = FB_DATA_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              avs_chipselect,
   input  logic              avs_write,
   input  logic              avs_read,
   input  logic [2:0]        avs_address,
   input  logic [7:0]        avs_writedata,
   output logic [7:0]        avs_readdata,
   input  logic              scan_req,
   input  logic [9:0]        scan_x,
   input  logic [8:0]        scan_y,
   output logic [DATA_W-1:0] scan_data,
   output logic              scan_valid,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int              CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

   // Host-side pixel registers
   logic [9:0]        r_x;
   logic [8:0]        r_y;
   logic [7:0]        r_color;
   logic              r_err_range;
   logic              r_err_ovf;
   logic [7:0]        r_readdata;
   logic              r_scan_valid;

   // Control FSM state
   fb_state_e         r_state;
   logic [ADDR_W-1:0] r_fill_cnt;
   logic [DATA_W-1:0] r_fill_color;
   logic              r_fill_pend;

   logic              w_wr;
   logic              w_rd;
   logic              w_commit;
   logic              w_fill_strobe;
   logic              w_in_range;
   logic              w_push;
   logic              w_pop;
   logic              w_fill_wr;
   logic              w_full;
   logic              w_empty;
   logic [CW-1:0]     w_count;
   logic [ADDR_W-1:0] w_commit_addr;
   logic [ADDR_W-1:0] w_scan_addr;
   fb_wr_t            w_push_data;
   fb_wr_t            w_head;

   assign w_wr          = avs_chipselect && avs_write;
   assign w_rd          = avs_chipselect && avs_read;
   assign w_commit      = w_wr && (avs_address == REG_COMMIT);
   assign w_fill_strobe = w_wr && (avs_address == REG_FILL);

   // Full-width address products so 639 + 479*640 never wraps
   assign w_commit_addr = ADDR_W'(r_y) * ADDR_W'(H_RES) + ADDR_W'(r_x);
   assign w_scan_addr   = ADDR_W'(scan_y) * ADDR_W'(H_RES) + ADDR_W'(scan_x);
   assign w_in_range    = (32'(r_x) < 32'(H_RES)) && (32'(r_y) < 32'(V_RES));

   // A full queue still accepts a push when the drain pops the head this cycle
   assign w_push        = w_commit && w_in_range && (!w_full || w_pop);
   assign w_push_data   = '{addr: FB_ADDR_W'(w_commit_addr), data: FB_DATA_W'(r_color)};

   fb_wr_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_wr_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // RAM port mux: scanout first, then queued writes or fill, all blocked in reset
   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      w_pop     = 1'b0;
      w_fill_wr = 1'b0;
      if (!reset) begin
         if (scan_req) begin
            mem_addr = w_scan_addr;
         end else if (r_state == ST_DRAIN && !w_empty) begin
            mem_we    = 1'b1;
            mem_addr  = ADDR_W'(w_head.addr);
            mem_wdata = DATA_W'(w_head.data);
            w_pop     = 1'b1;
         end else if (r_state == ST_FILL) begin
            mem_we    = 1'b1;
            mem_addr  = r_fill_cnt;
            mem_wdata = r_fill_color;
            w_fill_wr = 1'b1;
         end
      end
   end

   // Host register file and sticky error bits (a new error wins over a clear)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_x         <= '0;
         r_y         <= '0;
         r_color     <= '0;
         r_err_range <= 1'b0;
         r_err_ovf   <= 1'b0;
      end else begin
         if (w_wr) begin
            case (avs_address)
               REG_X_LO:   r_x[7:0] <= avs_writedata;
               REG_X_HI:   r_x[9:8] <= avs_writedata[1:0];
               REG_Y_LO:   r_y[7:0] <= avs_writedata;
               REG_Y_HI:   r_y[8]   <= avs_writedata[0];
               REG_COLOR:  r_color  <= avs_writedata;
               REG_STATUS: begin
                  r_err_range <= 1'b0;
                  r_err_ovf   <= 1'b0;
               end
               default: ;
            endcase
         end
         if (w_commit && !w_in_range)                      r_err_range <= 1'b1;
         if (w_commit && w_in_range && w_full && !w_pop)   r_err_ovf   <= 1'b1;
      end
   end

   // Registered status read and one-cycle scanout valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_readdata   <= '0;
         r_scan_valid <= 1'b0;
      end else begin
         r_scan_valid <= scan_req;
         if (w_rd && avs_address == REG_STATUS)
            r_readdata <= {4'b0, r_err_range, r_err_ovf, (r_state == ST_FILL), w_empty};
         else
            r_readdata <= '0;
      end
   end

   assign avs_readdata = r_readdata;
   assign scan_valid   = r_scan_valid;
   assign scan_data    = r_scan_valid ? mem_rdata : '0;

   // Control FSM: idle / drain queued writes / fill screen
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_fill_cnt   <= '0;
         r_fill_color <= '0;
         r_fill_pend  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // Fill outranks draining; queued entries wait until it ends
               if (w_fill_strobe || r_fill_pend) begin
                  r_state     <= ST_FILL;
                  r_fill_pend <= 1'b0;
                  r_fill_cnt  <= '0;
                  if (w_fill_strobe) r_fill_color <= DATA_W'(r_color);
               end else if (!w_empty) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (w_fill_strobe) begin
                  r_fill_pend  <= 1'b1;
                  r_fill_color <= DATA_W'(r_color);
               end
               if (w_empty || (w_pop && !w_push && w_count == CW'(1)))
                  r_state <= ST_IDLE;
            end
            ST_FILL: begin
               if (w_fill_wr) begin
                  if (r_fill_cnt == LAST_ADDR) begin
                     r_fill_cnt <= '0;
                     r_state    <= ST_IDLE;
                  end else begin
                     r_fill_cnt <= r_fill_cnt + 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_access_ctrl.sv
// Directed bench for fb_access_ctrl on a reduced 64x48 screen so full fills
// stay short. A negedge monitor logs every RAM write and checks scanout timing.
module tb_fb_access_ctrl;

  localparam int H    = 64;
  localparam int V    = 48;
  localparam int SIZE = H * V;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        avs_chipselect = 1'b0;
  logic        avs_write = 1'b0;
  logic        avs_read = 1'b0;
  logic [2:0]  avs_address = '0;
  logic [7:0]  avs_writedata = '0;
  logic [7:0]  avs_readdata;
  logic        scan_req = 1'b0;
  logic [9:0]  scan_x = '0;
  logic [8:0]  scan_y = '0;
  logic [7:0]  scan_data;
  logic        scan_valid;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;

  int checks = 0;
  int failures = 0;
  int viol = 0;
  int scan_err = 0;
  logic [26:0] wq[$];
  logic [26:0] exp_q[$];
  logic        prev_req = 1'b0;
  logic [7:0]  exp_sd = '0;

  fb_access_ctrl #(
    .H_RES(H), .V_RES(V), .ADDR_W(19), .DATA_W(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .avs_chipselect(avs_chipselect), .avs_write(avs_write), .avs_read(avs_read),
    .avs_address(avs_address), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .scan_req(scan_req), .scan_x(scan_x), .scan_y(scan_y),
    .scan_data(scan_data), .scan_valid(scan_valid),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // clock / RAM read model
  always #5 clk = ~clk;
  always @(posedge clk) mem_rdata <= mem_addr[7:0] ^ 8'h3C;

  function automatic logic [7:0] pix(input logic [9:0] x, input logic [8:0] y);
    int a;
    a = int'(y) * H + int'(x);
    return a[7:0] ^ 8'h3C;
  endfunction

  // monitor: log writes, flag writes in scan cycles, check scanout latency/data
  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (mem_we) begin
        wq.push_back({mem_addr, mem_wdata});
        if (scan_req) viol++;
      end
      if (scan_valid !== prev_req) scan_err++;
      if (prev_req && scan_data !== exp_sd) scan_err++;
      prev_req = scan_req;
      exp_sd   = pix(scan_x, scan_y);
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic avs_wr(input logic [2:0] a, input logic [7:0] d);
    cyc();
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = a; avs_writedata = d;
    cyc();
    avs_chipselect = 1'b0; avs_write = 1'b0;
  endtask

  task automatic avs_rd(input logic [2:0] a, output logic [7:0] d);
    cyc();
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = a;
    cyc();
    d = avs_readdata;
    avs_chipselect = 1'b0; avs_read = 1'b0;
  endtask

  task automatic set_xy(input logic [9:0] x, input logic [8:0] y);
    avs_wr(3'd0, x[7:0]);
    avs_wr(3'd1, {6'b0, x[9:8]});
    avs_wr(3'd2, y[7:0]);
    avs_wr(3'd3, {7'b0, y[8]});
  endtask

  task automatic test_reset();
    logic [7:0] st;
    reset = 1'b1;
    repeat (3) cyc();
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 19'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", mem_addr); end
    checks++; if (scan_valid !== 1'b0 || scan_data !== 8'h00) begin failures++; $display("FAIL reset_scan got=%b/%h exp=0/00", scan_valid, scan_data); end
    checks++; if (avs_readdata !== 8'h00) begin failures++; $display("FAIL reset_readdata got=%h exp=00", avs_readdata); end
    reset = 1'b0;
    cyc();
    avs_rd(3'd7, st);
    checks++; if (st !== 8'h01) begin failures++; $display("FAIL reset_status got=%h exp=01", st); end
    avs_rd(3'd2, st);
    checks++; if (st !== 8'h00) begin failures++; $display("FAIL other_addr_read got=%h exp=00", st); end
  endtask

  task automatic test_single_write();
    logic [7:0] st;
    wq.delete();
    set_xy(10'd10, 9'd2);
    avs_wr(3'd4, 8'hAB);
    avs_wr(3'd5, 8'h00);
    for (int i = 0; i < 3 && wq.size() == 0; i++) cyc();
    checks++;
    if (wq.size() != 1 || wq[0] !== {19'd138, 8'hAB}) begin
      failures++; $display("FAIL single_write got_n=%0d got=%h exp=%h", wq.size(), (wq.size() > 0) ? wq[0] : 27'h0, {19'd138, 8'hAB});
    end
    avs_rd(3'd7, st);
    checks++; if (st !== 8'h01) begin failures++; $display("FAIL single_status got=%h exp=01", st); end
  endtask

  task automatic test_scan_priority();
    int n;
    wq.delete(); exp_q.delete(); viol = 0; scan_err = 0;
    scan_x = 10'd5; scan_y = 9'd3; scan_req = 1'b1;
    set_xy(10'd0, 9'd4);
    for (int k = 0; k < 3; k++) begin
      avs_wr(3'd0, 8'(k * 7));
      avs_wr(3'd4, 8'(8'h10 + k));
      avs_wr(3'd5, 8'h00);
      exp_q.push_back({19'(4 * H + k * 7), 8'(8'h10 + k)});
    end
    checks++; if (wq.size() != 0) begin failures++; $display("FAIL scan_blocks_writes got=%0d exp=0", wq.size()); end
    scan_req = 1'b0;
    for (int i = 0; i < 8 && wq.size() < 3; i++) cyc();
    cyc();
    checks++; if (wq.size() != 3) begin failures++; $display("FAIL scan_retire_count got=%0d exp=3", wq.size()); end
    n = 0;
    for (int i = 0; i < 3 && i < wq.size(); i++) if (wq[i] !== exp_q[i]) n++;
    checks++; if (n != 0) begin failures++; $display("FAIL scan_retire_order got=%0d bad exp=0", n); end
    checks++; if (viol != 0 || scan_err != 0) begin failures++; $display("FAIL scan_timing got=%0d/%0d exp=0/0", viol, scan_err); end
  endtask

  task automatic test_overflow();
    logic [7:0] st;
    int n;
    wq.delete(); exp_q.delete(); viol = 0;
    scan_req = 1'b1; scan_x = 10'd1; scan_y = 9'd1;
    set_xy(10'd0, 9'd1);
    avs_wr(3'd4, 8'h5A);
    for (int k = 0; k < 5; k++) begin
      avs_wr(3'd0, 8'(k));
      avs_wr(3'd5, 8'h00);
      if (k < 4) exp_q.push_back({19'(H + k), 8'h5A});
    end
    avs_rd(3'd7, st);
    checks++; if (st !== 8'h04) begin failures++; $display("FAIL ovf_status got=%h exp=04", st); end
    avs_wr(3'd7, 8'h00);
    avs_rd(3'd7, st);
    checks++; if (st !== 8'h00) begin failures++; $display("FAIL ovf_clear got=%h exp=00", st); end
    scan_req = 1'b0;
    for (int i = 0; i < 10 && wq.size() < 4; i++) cyc();
    repeat (3) cyc();
    checks++; if (wq.size() != 4) begin failures++; $display("FAIL ovf_count got=%0d exp=4", wq.size()); end
    n = 0;
    for (int i = 0; i < 4 && i < wq.size(); i++) if (wq[i] !== exp_q[i]) n++;
    checks++; if (n != 0) begin failures++; $display("FAIL ovf_order got=%0d bad exp=0", n); end
    checks++; if (viol != 0) begin failures++; $display("FAIL ovf_scan_write got=%0d exp=0", viol); end
  endtask

  task automatic test_range();
    logic [7:0] st;
    wq.delete();
    set_xy(10'd640, 9'd0);
    avs_wr(3'd5, 8'h00);
    set_xy(10'd64, 9'd0);
    avs_wr(3'd5, 8'h00);
    set_xy(10'd0, 9'd48);
    avs_wr(3'd5, 8'h00);
    repeat (4) cyc();
    checks++; if (wq.size() != 0) begin failures++; $display("FAIL range_no_push got=%0d exp=0", wq.size()); end
    avs_rd(3'd7, st);
    checks++; if (st !== 8'h09) begin failures++; $display("FAIL range_status got=%h exp=09", st); end
    avs_wr(3'd7, 8'hFF);
    set_xy(10'd63, 9'd47);
    avs_wr(3'd4, 8'hE7);
    avs_wr(3'd5, 8'h00);
    for (int i = 0; i < 4 && wq.size() == 0; i++) cyc();
    checks++;
    if (wq.size() != 1 || wq[0] !== {19'd3071, 8'hE7}) begin
      failures++; $display("FAIL range_max_addr got_n=%0d got=%h exp=%h", wq.size(), (wq.size() > 0) ? wq[0] : 27'h0, {19'd3071, 8'hE7});
    end
    avs_rd(3'd7, st);
    checks++; if (st !== 8'h01) begin failures++; $display("FAIL range_clear got=%h exp=01", st); end
  endtask

  task automatic test_fill();
    logic [7:0] st;
    int n;
    wq.delete(); viol = 0; scan_err = 0;
    avs_wr(3'd4, 8'h55);
    avs_wr(3'd6, 8'h00);
    avs_rd(3'd7, st);
    checks++; if (st !== 8'h03) begin failures++; $display("FAIL fill_busy got=%h exp=03", st); end
    avs_wr(3'd6, 8'h00);
    for (int i = 0; i < SIZE + 100 && wq.size() < SIZE; i++) cyc();
    repeat (4) cyc();
    checks++; if (wq.size() != SIZE) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", wq.size(), SIZE); end
    n = 0;
    for (int i = 0; i < wq.size(); i++) if (wq[i] !== {19'(i), 8'h55}) n++;
    checks++; if (n != 0) begin failures++; $display("FAIL fill_content got=%0d bad exp=0", n); end
    avs_rd(3'd7, st);
    checks++; if (st !== 8'h01) begin failures++; $display("FAIL fill_done_status got=%h exp=01", st); end

    // second fill with scanout on every other cycle; must restart at 0
    wq.delete();
    avs_wr(3'd4, 8'hC3);
    avs_wr(3'd6, 8'h00);
    for (int i = 0; i < 3 * SIZE && wq.size() < SIZE; i++) begin
      cyc();
      scan_req = ~scan_req;
      scan_x = 10'(i % H);
      scan_y = 9'((i / H) % V);
    end
    scan_req = 1'b0;
    repeat (4) cyc();
    checks++; if (wq.size() != SIZE) begin failures++; $display("FAIL fill2_count got=%0d exp=%0d", wq.size(), SIZE); end
    n = 0;
    for (int i = 0; i < wq.size(); i++) if (wq[i] !== {19'(i), 8'hC3}) n++;
    checks++; if (n != 0) begin failures++; $display("FAIL fill2_content got=%0d bad exp=0", n); end
    checks++; if (viol != 0 || scan_err != 0) begin failures++; $display("FAIL fill2_scan got=%0d/%0d exp=0/0", viol, scan_err); end
  endtask

  task automatic test_reset_mid_fill();
    logic [7:0] st;
    wq.delete();
    avs_wr(3'd6, 8'h00);
    for (int i = 0; i < 2000 && wq.size() < 1000; i++) cyc();
    checks++; if (wq.size() != 1000) begin failures++; $display("FAIL midfill_reach got=%0d exp=1000", wq.size()); end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 19'd0 || mem_wdata !== 8'h00) begin
      failures++; $display("FAIL midfill_outputs got=%b/%0d/%h exp=0/0/00", mem_we, mem_addr, mem_wdata);
    end
    repeat (2) cyc();
    reset = 1'b0;
    avs_rd(3'd7, st);
    checks++; if (st !== 8'h01) begin failures++; $display("FAIL midfill_idle got=%h exp=01", st); end
    avs_wr(3'd4, 8'h77);
    wq.delete();
    avs_wr(3'd6, 8'h00);
    for (int i = 0; i < 4 && wq.size() == 0; i++) cyc();
    checks++;
    if (wq.size() == 0 || wq[0] !== {19'd0, 8'h77}) begin
      failures++; $display("FAIL midfill_restart got=%h exp=%h", (wq.size() > 0) ? wq[0] : 27'h0, {19'd0, 8'h77});
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_scan_priority();
    test_overflow();
    test_range();
    test_fill();
    test_reset_mid_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
